// File: rtl/add_accum_ctrl.sv
// Accumulation sequencer around an external combinational adder: takes NUM operands over
// valid/ready, folds each into the accumulator, then offers total, overflow and carry count.
module add_accum_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_ops,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_cin,
  input  logic [WIDTH-1:0] i_add_sum,
  input  logic             i_add_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_carry_cnt,
  output logic             o_busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_acc, w_acc_d;
  logic [CNT_W-1:0]   r_rem, w_rem_d;
  logic               r_ovf, w_ovf_d;
  logic [CNT_W-1:0]   r_ccnt, w_ccnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_ccnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_rem   <= w_rem_d;
      r_ovf   <= w_ovf_d;
      r_ccnt  <= w_ccnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_rem_d   = r_rem;
    w_ovf_d   = r_ovf;
    w_ccnt_d  = r_ccnt;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_acc_d   = '0;
          w_ovf_d   = 1'b0;
          w_ccnt_d  = '0;
          w_rem_d   = i_num_ops;
          w_state_d = (i_num_ops == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (i_in_valid) begin
          w_acc_d = i_add_sum;
          w_ovf_d = r_ovf | i_add_cout;
          // Carry count saturates rather than wrapping.
          if (i_add_cout && (r_ccnt != {CNT_W{1'b1}})) begin
            w_ccnt_d = r_ccnt + CNT_W'(1);
          end
          w_rem_d = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        if (i_out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_in_ready  = (r_state == StAccum);
  assign o_out_valid = (r_state == StDone);
  assign o_busy      = (r_state != StIdle);
  assign o_add_a     = r_acc;
  assign o_add_b     = i_in_data;
  assign o_add_cin   = 1'b0;
  assign o_result    = r_acc;
  assign o_overflow  = r_ovf;
  assign o_carry_cnt = r_ccnt;

endmodule

// File: tb/tb_add_accum_ctrl.sv
// Directed bench for add_accum_ctrl; models the external ripple-carry adder behaviourally.
module tb_add_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_ops;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic [3:0]  carry_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  add_accum_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_num_ops   (num_ops),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_cin   (add_cin),
    .i_add_sum   (add_sum),
    .i_add_cout  (add_cout),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_overflow  (overflow),
    .o_carry_cnt (carry_cnt),
    .o_busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue start at a negedge; t0 marks the cycle count before the sampling edge.
  task automatic do_start(input logic [3:0] n);
    start   = 1'b1;
    num_ops = n;
    t0      = cyc;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d, input int gap);
    int k;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_ovalid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_ops = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_carry_cnt", 32'(carry_cnt), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);

    // T1: three operands back-to-back
    do_start(4'd3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    in_data = 16'h0001;
    check("t1_add_b", 32'(add_b), 32'h0001);
    check("t1_add_cin", 32'(add_cin), 32'd0);
    feed(16'h0001, 0);
    feed(16'h0002, 0);
    check("t1_add_a_mid", 32'(add_a), 32'h0003);
    feed(16'h0003, 0);
    wait_out();
    check("t1_latency", 32'(cyc - t0), 32'd4);
    check("t1_result", 32'(result), 32'h0006);
    check("t1_overflow", 32'(overflow), 32'd0);
    check("t1_carry_cnt", 32'(carry_cnt), 32'd0);
    take_result("t1");
    check("t1_result_held_idle", 32'(result), 32'h0006);

    // T4: zero operands goes straight to DONE
    do_start(4'd0);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    check("t4_latency", 32'(cyc - t0), 32'd1);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    check("t4_result", 32'(result), 32'h0000);
    check("t4_overflow", 32'(overflow), 32'd0);
    take_result("t4");

    // T2: wrap with a single carry
    do_start(4'd2);
    feed(16'hFFFF, 0);
    feed(16'h0001, 0);
    wait_out();
    check("t2_result", 32'(result), 32'h0000);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_carry_cnt", 32'(carry_cnt), 32'd1);
    take_result("t2");

    // T3: 0x8000 x4 with two-cycle gaps between operands
    do_start(4'd4);
    feed(16'h8000, 0);
    feed(16'h8000, 2);
    feed(16'h8000, 2);
    feed(16'h8000, 2);
    wait_out();
    check("t3_latency", 32'(cyc - t0), 32'd11);
    check("t3_result", 32'(result), 32'h0000);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_carry_cnt", 32'(carry_cnt), 32'd2);
    take_result("t3");

    // T5: DONE held under back-pressure; start pulses ignored
    do_start(4'd1);
    feed(16'h00AB, 0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      num_ops = 4'd2;
      tick();
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_result", 32'(result), 32'h00AB);
    end
    start = 1'b1;
    take_result("t5");
    start = 1'b0;
    check("t5_in_ready", 32'(in_ready), 32'd0);

    // T6: reset mid-run, then a fresh run
    do_start(4'd3);
    feed(16'h5555, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_acc", 32'(result), 32'h0000);
    do_start(4'd3);
    feed(16'h1234, 0);
    feed(16'h1111, 0);
    feed(16'h0001, 0);
    wait_out();
    check("t6_result", 32'(result), 32'h2346);
    check("t6_overflow", 32'(overflow), 32'd0);
    take_result("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
